// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: one symbolic instruction in, one or two
// 32-bit machine words out, with a one-word output register and an LI queue slot.
module instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_op,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_shamt,
    input  logic [31:0]      in_imm,
    input  logic [25:0]      in_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [CNT_W-1:0] out_count,
    output logic             err
);

    localparam logic [5:0] OP_NOP    = 6'd0,  OP_SLL    = 6'd1,  OP_SRL    = 6'd2;
    localparam logic [5:0] OP_SRA    = 6'd3,  OP_SLLV   = 6'd4,  OP_SRLV   = 6'd5;
    localparam logic [5:0] OP_SRAV   = 6'd6,  OP_ADD    = 6'd7,  OP_ADDU   = 6'd8;
    localparam logic [5:0] OP_SUB    = 6'd9,  OP_SUBU   = 6'd10, OP_AND    = 6'd11;
    localparam logic [5:0] OP_OR     = 6'd12, OP_XOR    = 6'd13, OP_NOR    = 6'd14;
    localparam logic [5:0] OP_SLT    = 6'd15, OP_SLTU   = 6'd16, OP_SYSCALL = 6'd17;
    localparam logic [5:0] OP_JR     = 6'd18, OP_JALR   = 6'd19, OP_J      = 6'd20;
    localparam logic [5:0] OP_JAL    = 6'd21, OP_BEQ    = 6'd22, OP_BNE    = 6'd23;
    localparam logic [5:0] OP_BGTZ   = 6'd24, OP_BLEZ   = 6'd25, OP_BLTZ   = 6'd26;
    localparam logic [5:0] OP_BLTZAL = 6'd27, OP_BGEZ   = 6'd28, OP_BGEZAL = 6'd29;
    localparam logic [5:0] OP_ADDI   = 6'd30, OP_ADDIU  = 6'd31, OP_ANDI   = 6'd32;
    localparam logic [5:0] OP_ORI    = 6'd33, OP_XORI   = 6'd34, OP_SLTI   = 6'd35;
    localparam logic [5:0] OP_SLTIU  = 6'd36, OP_LH     = 6'd37, OP_LW     = 6'd38;
    localparam logic [5:0] OP_SW     = 6'd39, OP_LUI    = 6'd40, OP_ERET   = 6'd41;
    localparam logic [5:0] OP_MFC0   = 6'd42, OP_MTC0   = 6'd43, OP_LI     = 6'd44;

    localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_REGIMM = 6'h01, OPC_J    = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03, OPC_BEQ    = 6'h04, OPC_BNE  = 6'h05;
    localparam logic [5:0] OPC_BLEZ    = 6'h06, OPC_BGTZ   = 6'h07, OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_ADDIU   = 6'h09, OPC_SLTI   = 6'h0A, OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI    = 6'h0C, OPC_ORI    = 6'h0D, OPC_XORI = 6'h0E;
    localparam logic [5:0] OPC_LUI     = 6'h0F, OPC_COP0   = 6'h10, OPC_LH   = 6'h21;
    localparam logic [5:0] OPC_LW      = 6'h23, OPC_SW     = 6'h2B;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_PEND
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_out_instr;
    logic [31:0]      r_pend_instr;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic [31:0]      w_word0;
    logic [31:0]      w_word1;
    logic             w_two;
    logic             w_illegal;
    logic             w_accept;
    logic             w_out_fire;
    logic             w_load_out;
    logic             w_load_ori;

    function automatic logic [31:0] f_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [4:0] sh,
                                             input logic [5:0] funct);
        return {OPC_SPECIAL, rs, rt, rd, sh, funct};
    endfunction

    function automatic logic [31:0] f_itype(input logic [5:0] opc, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_word0   = 32'h0;
        w_word1   = 32'h0;
        w_two     = 1'b0;
        w_illegal = 1'b0;
        case (in_op)
            OP_NOP:     w_word0 = 32'h0000_0000;
            OP_SLL:     w_word0 = f_rtype(REG_ZERO, in_rt, in_rd, in_shamt, 6'h00);
            OP_SRL:     w_word0 = f_rtype(REG_ZERO, in_rt, in_rd, in_shamt, 6'h02);
            OP_SRA:     w_word0 = f_rtype(REG_ZERO, in_rt, in_rd, in_shamt, 6'h03);
            OP_SLLV:    w_word0 = f_rtype(in_rs, in_rt, in_rd, REG_ZERO, 6'h04);
            OP_SRLV:    w_word0 = f_rtype(in_rs, in_rt, in_rd, REG_ZERO, 6'h06);
            OP_SRAV:    w_word0 = f_rtype(in_rs, in_rt, in_rd, REG_ZERO, 6'h07);
            OP_ADD:     w_word0 = f_rtype(in_rs, in_rt, in_rd, REG_ZERO, 6'h20);
            OP_ADDU:    w_word0 = f_rtype(in_rs, in_rt, in_rd, REG_ZERO, 6'h21);
            OP_SUB:     w_word0 = f_rtype(in_rs, in_rt, in_rd, REG_ZERO, 6'h22);
            OP_SUBU:    w_word0 = f_rtype(in_rs, in_rt, in_rd, REG_ZERO, 6'h23);
            OP_AND:     w_word0 = f_rtype(in_rs, in_rt, in_rd, REG_ZERO, 6'h24);
            OP_OR:      w_word0 = f_rtype(in_rs, in_rt, in_rd, REG_ZERO, 6'h25);
            OP_XOR:     w_word0 = f_rtype(in_rs, in_rt, in_rd, REG_ZERO, 6'h26);
            OP_NOR:     w_word0 = f_rtype(in_rs, in_rt, in_rd, REG_ZERO, 6'h27);
            OP_SLT:     w_word0 = f_rtype(in_rs, in_rt, in_rd, REG_ZERO, 6'h2A);
            OP_SLTU:    w_word0 = f_rtype(in_rs, in_rt, in_rd, REG_ZERO, 6'h2B);
            OP_SYSCALL: w_word0 = 32'h0000_000C;
            OP_JR:      w_word0 = f_rtype(in_rs, REG_ZERO, REG_ZERO, REG_ZERO, 6'h08);
            OP_JALR:    w_word0 = f_rtype(in_rs, REG_ZERO, 5'd31, REG_ZERO, 6'h09);
            OP_J:       w_word0 = {OPC_J, in_target};
            OP_JAL:     w_word0 = {OPC_JAL, in_target};
            OP_BEQ:     w_word0 = f_itype(OPC_BEQ, in_rs, in_rt, in_imm[15:0]);
            OP_BNE:     w_word0 = f_itype(OPC_BNE, in_rs, in_rt, in_imm[15:0]);
            OP_BGTZ:    w_word0 = f_itype(OPC_BGTZ, in_rs, REG_ZERO, in_imm[15:0]);
            OP_BLEZ:    w_word0 = f_itype(OPC_BLEZ, in_rs, REG_ZERO, in_imm[15:0]);
            OP_BLTZ:    w_word0 = f_itype(OPC_REGIMM, in_rs, 5'b00000, in_imm[15:0]);
            OP_BLTZAL:  w_word0 = f_itype(OPC_REGIMM, in_rs, 5'b10000, in_imm[15:0]);
            OP_BGEZ:    w_word0 = f_itype(OPC_REGIMM, in_rs, 5'b00001, in_imm[15:0]);
            OP_BGEZAL:  w_word0 = f_itype(OPC_REGIMM, in_rs, 5'b10001, in_imm[15:0]);
            OP_ADDI:    w_word0 = f_itype(OPC_ADDI, in_rs, in_rt, in_imm[15:0]);
            OP_ADDIU:   w_word0 = f_itype(OPC_ADDIU, in_rs, in_rt, in_imm[15:0]);
            OP_ANDI:    w_word0 = f_itype(OPC_ANDI, in_rs, in_rt, in_imm[15:0]);
            OP_ORI:     w_word0 = f_itype(OPC_ORI, in_rs, in_rt, in_imm[15:0]);
            OP_XORI:    w_word0 = f_itype(OPC_XORI, in_rs, in_rt, in_imm[15:0]);
            OP_SLTI:    w_word0 = f_itype(OPC_SLTI, in_rs, in_rt, in_imm[15:0]);
            OP_SLTIU:   w_word0 = f_itype(OPC_SLTIU, in_rs, in_rt, in_imm[15:0]);
            OP_LH:      w_word0 = f_itype(OPC_LH, in_rs, in_rt, in_imm[15:0]);
            OP_LW:      w_word0 = f_itype(OPC_LW, in_rs, in_rt, in_imm[15:0]);
            OP_SW:      w_word0 = f_itype(OPC_SW, in_rs, in_rt, in_imm[15:0]);
            OP_LUI:     w_word0 = f_itype(OPC_LUI, REG_ZERO, in_rt, in_imm[15:0]);
            OP_ERET:    w_word0 = 32'h4200_0018;
            OP_MFC0:    w_word0 = {OPC_COP0, 5'b00000, in_rt, in_rd, 11'b0};
            OP_MTC0:    w_word0 = {OPC_COP0, 5'b00100, in_rt, in_rd, 11'b0};
            OP_LI: begin
                // Sign-extendable constants fit one ADDIU; low-half-zero ones fit one LUI.
                if ((&in_imm[31:15]) || !(|in_imm[31:15])) begin
                    w_word0 = f_itype(OPC_ADDIU, REG_ZERO, in_rt, in_imm[15:0]);
                end else if (in_imm[15:0] == 16'h0) begin
                    w_word0 = f_itype(OPC_LUI, REG_ZERO, in_rt, in_imm[31:16]);
                end else begin
                    w_word0 = f_itype(OPC_LUI, REG_ZERO, in_rt, in_imm[31:16]);
                    w_word1 = f_itype(OPC_ORI, in_rt, in_rt, in_imm[15:0]);
                    w_two   = 1'b1;
                end
            end
            default:    w_illegal = 1'b1;
        endcase
    end

    // Input is blocked while reset is held, even though the state reads EMPTY.
    assign in_ready   = !rst && ((r_state == ST_EMPTY) || ((r_state == ST_FULL) && out_ready));
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_accept   = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load_out  = 1'b0;
        w_load_ori  = 1'b0;
        case (r_state)
            ST_EMPTY, ST_FULL: begin
                if (w_accept && !w_illegal) begin
                    w_load_out  = 1'b1;
                    w_state_nxt = w_two ? ST_PEND : ST_FULL;
                end else if ((r_state == ST_EMPTY) || out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_PEND: begin
                if (out_ready) begin
                    w_load_ori  = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_instr  <= 32'h0;
            r_pend_instr <= 32'h0;
            r_count      <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_load_out) begin
                r_out_instr <= w_word0;
            end else if (w_load_ori) begin
                r_out_instr <= r_pend_instr;
            end
            if (w_load_out && w_two) begin
                r_pend_instr <= w_word1;
            end
            if (w_out_fire) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_accept && w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out_instr = r_out_instr;
    assign out_count = r_count;
    assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a randomized
// stream scored against a table-driven encoding model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_op = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [31:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [15:0] out_count;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [15:0] exp_count = '0;
    logic        exp_err = 1'b0;

    localparam int unsigned SHIFT_FN [6]  = '{0, 2, 3, 4, 6, 7};
    localparam int unsigned ALU_FN   [10] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
    localparam int unsigned IALU_OPC [7]  = '{8, 9, 12, 13, 14, 10, 11};
    localparam int unsigned BR_OPC   [4]  = '{4, 5, 7, 6};
    localparam int unsigned REGIMM_RT[4]  = '{0, 16, 1, 17};
    localparam int unsigned MEM_OPC  [3]  = '{33, 35, 43};

    instr_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_count(out_count), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(int unsigned opc, int unsigned rs, int unsigned rt,
                                         int unsigned rd, int unsigned sh, int unsigned fn);
        return 32'((opc << 26) | (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn);
    endfunction

    // Expected machine words for one symbolic instruction (0, 1 or 2 words).
    function automatic void ref_encode(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh, input logic [31:0] imm,
                                       input logic [25:0] tgt, output int n,
                                       output logic [31:0] w0, output logic [31:0] w1);
        int unsigned o;
        int unsigned lo;
        int signed   s;
        o  = op;
        lo = imm[15:0];
        s  = $signed(imm);
        n  = 1;
        w0 = 32'h0;
        w1 = 32'h0;
        if (o == 0)       w0 = 32'h0;
        else if (o <= 3)  w0 = word(0, 0, rt, rd, sh, SHIFT_FN[o-1]);
        else if (o <= 6)  w0 = word(0, rs, rt, rd, 0, SHIFT_FN[o-1]);
        else if (o <= 16) w0 = word(0, rs, rt, rd, 0, ALU_FN[o-7]);
        else if (o == 17) w0 = 32'h0000000C;
        else if (o == 18) w0 = word(0, rs, 0, 0, 0, 8);
        else if (o == 19) w0 = word(0, rs, 0, 31, 0, 9);
        else if (o <= 21) w0 = word(o - 18, 0, 0, 0, 0, 0) | 32'(tgt);
        else if (o <= 23) w0 = word(BR_OPC[o-22], rs, rt, 0, 0, 0) | lo;
        else if (o <= 25) w0 = word(BR_OPC[o-22], rs, 0, 0, 0, 0) | lo;
        else if (o <= 29) w0 = word(1, rs, REGIMM_RT[o-26], 0, 0, 0) | lo;
        else if (o <= 36) w0 = word(IALU_OPC[o-30], rs, rt, 0, 0, 0) | lo;
        else if (o <= 39) w0 = word(MEM_OPC[o-37], rs, rt, 0, 0, 0) | lo;
        else if (o == 40) w0 = word(15, 0, rt, 0, 0, 0) | lo;
        else if (o == 41) w0 = 32'h42000018;
        else if (o == 42) w0 = word(16, 0, rt, rd, 0, 0);
        else if (o == 43) w0 = word(16, 4, rt, rd, 0, 0);
        else if (o == 44) begin
            if (s >= -32768 && s <= 32767) w0 = word(9, 0, rt, 0, 0, 0) | lo;
            else if (lo == 0)              w0 = word(15, 0, rt, 0, 0, 0) | 32'(imm[31:16]);
            else begin
                n  = 2;
                w0 = word(15, 0, rt, 0, 0, 0) | 32'(imm[31:16]);
                w1 = word(13, rt, rt, 0, 0, 0) | lo;
            end
        end else          n = 0;
    endfunction

    // Scoreboard: sample between edges, predict on accept, compare on output fire.
    always @(negedge clk) begin
        int          n;
        logic [31:0] w0, w1, got;
        if (rst) begin
            exp_q.delete();
            exp_count = '0;
            exp_err   = 1'b0;
        end else begin
            n_checks++;
            if (err !== exp_err) begin
                n_errors++;
                $display("FAIL err_flag: got %b expected %b at %0t", err, exp_err, $time);
            end
            n_checks++;
            if (out_count !== exp_count) begin
                n_errors++;
                $display("FAIL out_count: got %0d expected %0d at %0t", out_count, exp_count, $time);
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL extra_word: got %h expected no word at %0t", out_instr, $time);
                end else begin
                    got = exp_q.pop_front();
                    if (out_instr !== got) begin
                        n_errors++;
                        $display("FAIL stream_word: got %h expected %h at %0t", out_instr, got, $time);
                    end
                end
                exp_count = exp_count + 16'd1;
            end
            if (in_valid && in_ready === 1'b1) begin
                ref_encode(in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, n, w0, w1);
                if (n >= 1) exp_q.push_back(w0);
                if (n == 2) exp_q.push_back(w1);
                if (n == 0) exp_err = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
        end
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] imm, input logic [25:0] tgt);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = 5'd0;
        in_imm = imm; in_target = tgt;
    endtask

    // Holds in_valid until accepted (bounded); returns at posedge+1 after the accept.
    task automatic wait_accept();
        int k;
        k = 0;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_instr", out_instr, 32'h0);
        chk("reset_out_count", 32'(out_count), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
    endtask

    task automatic test_addu();
        @(posedge clk); #1;
        out_ready = 1'b1;
        set_instr(6'd8, 5'd1, 5'd2, 5'd3, 32'h0, 26'h0);
        wait_accept();
        chk("addu_valid", 32'(out_valid), 32'd1);
        chk("addu_word", out_instr, 32'h00221821);
        chk("addu_count_before", 32'(out_count), 32'd0);
        @(posedge clk); #1;
        chk("addu_count_after", 32'(out_count), 32'd1);
        chk("addu_drained", 32'(out_valid), 32'd0);
    endtask

    task automatic test_li();
        logic [15:0] base;
        base = exp_count;
        out_ready = 1'b1;
        set_instr(6'd44, 5'd0, 5'd8, 5'd0, 32'h12345678, 26'h0);
        wait_accept();
        chk("li2_lui", out_instr, 32'h3C081234);
        chk("li2_blocked", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("li2_ori_valid", 32'(out_valid), 32'd1);
        chk("li2_ori", out_instr, 32'h35085678);
        chk("li2_unblocked", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("li2_count", 32'(out_count), 32'(base + 16'd2));
        set_instr(6'd44, 5'd0, 5'd8, 5'd0, 32'hFFFFFFFE, 26'h0);
        wait_accept();
        chk("li_addiu", out_instr, 32'h2408FFFE);
        @(posedge clk); #1;
        chk("li_addiu_single", 32'(out_valid), 32'd0);
        set_instr(6'd44, 5'd0, 5'd8, 5'd0, 32'h00070000, 26'h0);
        wait_accept();
        chk("li_lui", out_instr, 32'h3C080007);
        @(posedge clk); #1;
        chk("li_lui_single", 32'(out_valid), 32'd0);
        chk("li_count", 32'(out_count), 32'(base + 16'd4));
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_instr(6'd29, 5'd4, 5'd0, 5'd0, 32'h0000FFFC, 26'h0);
        @(posedge clk); #1;
        chk("b2b_bgezal", out_instr, 32'h0491FFFC);
        set_instr(6'd21, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0100000);
        @(posedge clk); #1;
        chk("b2b_jal", out_instr, 32'h0C100000);
        set_instr(6'd41, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_word", out_instr, 32'h0C100000);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_eret", out_instr, 32'h42000018);
        @(posedge clk); #1;
        chk("b2b_drained", 32'(out_valid), 32'd0);
    endtask

    task automatic test_illegal();
        logic [15:0] base;
        base = exp_count;
        out_ready = 1'b1;
        set_instr(6'd50, 5'd1, 5'd2, 5'd3, 32'h1234, 26'h0);
        wait_accept();
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_no_word", 32'(out_valid), 32'd0);
        set_instr(6'd17, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0);
        wait_accept();
        chk("syscall_word", out_instr, 32'h0000000C);
        @(posedge clk); #1;
        chk("illegal_count", 32'(out_count), 32'(base + 16'd1));
        chk("illegal_err_sticky", 32'(err), 32'd1);
    endtask

    task automatic test_reset_mid_li();
        out_ready = 1'b0;
        set_instr(6'd44, 5'd0, 5'd8, 5'd0, 32'h12345678, 26'h0);
        wait_accept();
        @(posedge clk); #1;
        chk("pend_hold", out_instr, 32'h3C081234);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_count", 32'(out_count), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_ori", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_op     = 6'($urandom_range(0, 63));
            in_rs     = 5'($urandom);
            in_rt     = 5'($urandom);
            in_rd     = 5'($urandom);
            in_shamt  = 5'($urandom);
            in_target = 26'($urandom);
            case ($urandom_range(0, 3))
                0:       in_imm = $urandom;
                1:       in_imm = 32'($signed(16'($urandom)));
                2:       in_imm = {16'($urandom), 16'h0};
                default: in_imm = {16'($urandom), 16'($urandom | 1)};
            endcase
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("random_drain_valid", 32'(out_valid), 32'd0);
        chk("random_drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addu();
        test_li();
        test_back_to_back();
        test_illegal();
        test_reset_mid_li();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming MIPS instruction encoder: accepts one symbolic instruction per handshake (mnemonic code plus register/immediate fields) and emits the 32-bit machine word(s) the core's instruction decoder accepts. It expands the `LI` pseudo-instruction into one or two words. It sits between the self-test program generator / boot loader and instruction memory. Its encodings are the bit-exact inverse of the decode tables for every instruction the core supports.

## Interface
Parameters:
- `CNT_W`, 16, width of the emitted-word counter.

Ports:
- `clk`  in  1  sole clock. All state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  symbolic instruction present.
- `in_ready`  out  1  encoder accepts the instruction this cycle.
- `in_op`  in  6  mnemonic code (see Operation).
- `in_rs`, `in_rt`, `in_rd`, `in_shamt`  in  5 each  register and shift fields.
- `in_imm`  in  32  immediate or branch offset (bits [15:0]). `LI` uses all 32 bits.
- `in_target`  in  26  J/JAL word target.
- `out_valid`  out  1  `out_instr` holds a valid word.
- `out_ready`  in  1  downstream consumes the word.
- `out_instr`  out  32  encoded machine word.
- `out_count`  out  CNT_W  number of words emitted; wraps modulo 2^CNT_W.
- `err`  out  1  sticky flag: an illegal `in_op` was accepted.

## Operation
Mnemonic codes:
- 0 NOP
- 1–6: SLL, SRL, SRA, SLLV, SRLV, SRAV
- 7–16: ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU
- 17 SYSCALL; 18 JR; 19 JALR; 20 J; 21 JAL
- 22–29: BEQ, BNE, BGTZ, BLEZ, BLTZ, BLTZAL, BGEZ, BGEZAL
- 30–36: ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU
- 37 LH; 38 LW; 39 SW; 40 LUI; 41 ERET; 42 MFC0; 43 MTC0; 44 LI
- 45–63 are illegal.

Field rules:
- R-type words are `{000000, rs, rt, rd, shamt, funct}`. Fields an instruction does not use are forced to 0.
- SLL/SRL/SRA place `in_shamt` in the shamt field. The variable shifts use rs as the shift amount.
- JR: `{0, rs, 0, 0, 0, 001000}`.
- JALR: rd = 31 and funct = 001001.
- SYSCALL: 0x0000000C. NOP: 0x00000000. ERET: 0x42000018.
- REGIMM branches use opcode 000001 with rt fixed: BLTZ 00000, BGEZ 00001, BLTZAL 10000, BGEZAL 10001.
- BGTZ/BLEZ force rt = 0.
- I-type words are `{opcode, rs, rt, imm[15:0]}`. LUI forces rs = 0.
- MFC0: `{010000, 00000, rt, rd, 11'b0}`. MTC0: same with rs field 00100.
- J/JAL: `{opcode, in_target}`.

LI rt, imm expansion:
- If imm[31:15] are all equal: single word ADDIU rt, $0, imm[15:0].
- Else if imm[15:0] == 0: single word LUI rt, imm[31:16].
- Else two words, in order: LUI rt, imm[31:16], then ORI rt, rt, imm[15:0].

Illegal op:
- Accepted normally (consumes the handshake).
- Emits no word and does not change `out_count`.
- Sets `err` = 1 from the next cycle until reset.

## Timing
State machine:
- EMPTY: output register empty.
- FULL: one word held.
- PEND: word held, and the ORI half of an LI is queued in an internal register.

Handshakes:
- `in_ready` = (state == EMPTY) | (state == FULL & out_ready). It is 0 in PEND and while `rst` is high.
- A transfer occurs when valid & ready on the same edge.
- Accept → `out_valid` = 1 on the next cycle, so latency is 1 cycle.
- Sustained throughput is 1 word/cycle. A two-word LI blocks input for exactly one extra cycle when `out_ready` = 1.

Transitions:
- EMPTY → FULL on accept of a single-word op.
- EMPTY → PEND on accept of a two-word LI.
- EMPTY stays EMPTY on accept of an illegal op.
- FULL with `out_ready`:
  - accept single-word op → stay FULL;
  - accept two-word LI → PEND;
  - accept illegal op or no input → EMPTY.
- PEND with `out_ready` → FULL, with the ORI word loaded into `out_instr`.

Output rules:
- `out_count` increments once per completed output transfer (`out_valid` & `out_ready`) and wraps to 0 after all ones.
- `out_instr` and `out_valid` are registered and stay stable while `out_valid` = 1 and `out_ready` = 0.

Reset values:
- `out_valid` = 0, `out_instr` = 0, `out_count` = 0, `err` = 0, state = EMPTY.
- Reset asserted mid-LI (in PEND) discards both the held word and the queued word.
- Words emitted before reset are not recounted.

## Test plan
- ADDU rd=3, rs=1, rt=2, with `out_ready` held 1 → `out_instr` = 0x00221821 one cycle after accept; `out_count` 0 → 1.
- LI rt=8, imm=0x12345678 → 0x3C081234, then 0x35085678 on consecutive cycles; `in_ready` = 0 for the one intervening cycle; `out_count` += 2.
- LI rt=8, imm=0xFFFFFFFE → single word 0x2408FFFE. LI rt=8, imm=0x00070000 → single word 0x3C080007.
- Back-to-back stream BGEZAL rs=4, imm=0xFFFC; JAL target=0x0100000; ERET → 0x0491FFFC, 0x0C100000, 0x42000018 on 3 consecutive cycles. Hold `out_ready` = 0 for 3 cycles mid-stream → word held stable and `in_ready` = 0 throughout.
- Illegal op 50, then SYSCALL → `err` = 1 from the cycle after the illegal accept; only 0x0000000C is emitted; `out_count` += 1.
- Issue LI 0x12345678 with `out_ready` = 0, then pulse `rst` in PEND → `out_valid` = 0 and `out_count` = 0 immediately (asynchronous); no ORI word appears after reset is released.
